// File: rtl/muldiv_if.sv
// Request / register-file write-back bundle between the issue stage and muldiv_unit.
// The master drives operation requests; the slave (the unit) returns status and the write port.
interface muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [4:0]       dest;
  logic             flush;
  logic             ready;
  logic             busy;
  logic             done;
  logic             we3;
  logic [4:0]       wa3;
  logic [WIDTH-1:0] wd3;

  modport master (
    output start, op, a, b, dest, flush,
    input  ready, busy, done, we3, wa3, wd3
  );

  modport slave (
    input  start, op, a, b, dest, flush,
    output ready, busy, done, we3, wa3, wd3
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative radix-2 unsigned multiply/divide unit: 32 steps per operation, then a
// one-cycle register-file write-back. All outputs come straight from flops.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     reset_n,
  muldiv_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_WB   = 2'd2
  } state_t;

  state_t               state_r, state_s;
  logic [1:0]           op_r, op_s;
  logic [WIDTH-1:0]     a_r, a_s;
  logic [WIDTH-1:0]     b_r, b_s;
  logic [4:0]           dest_r, dest_s;
  logic [5:0]           cnt_r, cnt_s;
  // MUL: {product high, remaining multiplier bits}; DIV: {remainder, quotient}.
  logic [2*WIDTH-1:0]   acc_r, acc_s;

  logic [WIDTH:0]       sum_s;
  logic [WIDTH:0]       shl_s;
  logic [WIDTH:0]       diff_s;
  logic                 divzero_s;

  logic                 ready_r, ready_s;
  logic                 busy_r, busy_s;
  logic                 done_r, done_s;
  logic                 we3_r, we3_s;
  logic [4:0]           wa3_r, wa3_s;
  logic [WIDTH-1:0]     wd3_r, wd3_s;

  // Odd opcodes (MULHI, REMU) take the upper accumulator half.
  function automatic logic [WIDTH-1:0] sel_result(input logic [1:0] op,
                                                  input logic [2*WIDTH-1:0] acc);
    logic [WIDTH-1:0] res;
    if (op[0]) begin
      res = acc[2*WIDTH-1:WIDTH];
    end else begin
      res = acc[WIDTH-1:0];
    end
    return res;
  endfunction

  // One shift-add and one restoring shift-subtract step from the current accumulator.
  always_comb begin
    sum_s  = {1'b0, acc_r[2*WIDTH-1:WIDTH]} +
             (acc_r[0] ? {1'b0, a_r} : {(WIDTH+1){1'b0}});
    shl_s  = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
    diff_s = shl_s - {1'b0, b_r};
  end

  // Next-state, operand capture and accumulator update.
  always_comb begin
    state_s   = state_r;
    op_s      = op_r;
    a_s       = a_r;
    b_s       = b_r;
    dest_s    = dest_r;
    cnt_s     = cnt_r;
    acc_s     = acc_r;
    divzero_s = bus.op[1] && (bus.b == {WIDTH{1'b0}});
    if (bus.flush) begin
      state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.start) begin
            op_s   = bus.op;
            a_s    = bus.a;
            b_s    = bus.b;
            dest_s = bus.dest;
            cnt_s  = 6'd0;
            if (divzero_s) begin
              // Preload quotient all-ones and remainder = dividend, go straight to WB.
              acc_s   = {bus.a, {WIDTH{1'b1}}};
              state_s = ST_WB;
            end else if (bus.op[1]) begin
              acc_s   = {{WIDTH{1'b0}}, bus.a};
              state_s = ST_RUN;
            end else begin
              acc_s   = {{WIDTH{1'b0}}, bus.b};
              state_s = ST_RUN;
            end
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_RUN: begin
          cnt_s = cnt_r + 6'd1;
          if (op_r[1]) begin
            if (!diff_s[WIDTH]) begin
              acc_s = {diff_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
            end else begin
              acc_s = {shl_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
            end
          end else begin
            acc_s = {sum_s, acc_r[WIDTH-1:1]};
          end
          if (cnt_r == 6'(WIDTH - 1)) begin
            state_s = ST_WB;
          end else begin
            state_s = ST_RUN;
          end
        end
        ST_WB: begin
          state_s = ST_IDLE;
        end
        default: begin
          state_s = ST_IDLE;
        end
      endcase
    end
  end

  // Output values for the cycle after the edge, derived from the next state.
  always_comb begin
    ready_s = (state_s == ST_IDLE);
    busy_s  = (state_s != ST_IDLE);
    if (state_s == ST_WB) begin
      done_s = 1'b1;
      we3_s  = (dest_s != 5'd0);
      wa3_s  = dest_s;
      wd3_s  = sel_result(op_s, acc_s);
    end else begin
      done_s = 1'b0;
      we3_s  = 1'b0;
      wa3_s  = 5'd0;
      wd3_s  = {WIDTH{1'b0}};
    end
  end

  // State, datapath and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
      op_r    <= 2'd0;
      a_r     <= {WIDTH{1'b0}};
      b_r     <= {WIDTH{1'b0}};
      dest_r  <= 5'd0;
      cnt_r   <= 6'd0;
      acc_r   <= {(2*WIDTH){1'b0}};
      ready_r <= 1'b1;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      we3_r   <= 1'b0;
      wa3_r   <= 5'd0;
      wd3_r   <= {WIDTH{1'b0}};
    end else begin
      state_r <= state_s;
      op_r    <= op_s;
      a_r     <= a_s;
      b_r     <= b_s;
      dest_r  <= dest_s;
      cnt_r   <= cnt_s;
      acc_r   <= acc_s;
      ready_r <= ready_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      we3_r   <= we3_s;
      wa3_r   <= wa3_s;
      wd3_r   <= wd3_s;
    end
  end

  assign bus.ready = ready_r;
  assign bus.busy  = busy_r;
  assign bus.done  = done_r;
  assign bus.we3   = we3_r;
  assign bus.wa3   = wa3_r;
  assign bus.wd3   = wd3_r;

endmodule
